crc32_enc_packer: RTL

CRC32_ENC_PACKER -- requirements
Module: crc32_enc_packer

---
 rtl/crc32_enc_packer.sv | 110 +++++++++++
 1 files changed

// File: rtl/crc32_enc_packer.sv
// Packs up to BEATS input beats, MSB-first, into one zero-padded codeword
// and appends an MSB-first CRC of the entire payload.
module crc32_enc_packer #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned BEAT_WIDTH = 64,
    parameter int unsigned CRC_WIDTH  = 32
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       s_valid_i,
    output logic                                       s_ready_o,
    input  logic [BEAT_WIDTH-1:0]                      s_data_i,
    input  logic                                       s_last_i,
    output logic                                       m_valid_o,
    input  logic                                       m_ready_i,
    output logic [DATA_WIDTH-1:0]                      m_data_o,
    output logic [CRC_WIDTH-1:0]                       m_crc_o,
    output logic [$clog2(DATA_WIDTH/BEAT_WIDTH):0]     m_beats_o
);

    localparam int unsigned BEATS = DATA_WIDTH / BEAT_WIDTH;
    localparam int unsigned CNT_W = $clog2(BEATS) + 1;
    localparam logic [CRC_WIDTH-1:0] POLY = CRC_WIDTH'(32'h0000_00AF);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CALC    = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CRC_WIDTH-1:0]  r_crc;
    logic                  r_s_ready;
    logic                  r_m_valid;

    logic                  w_accept;
    logic                  w_close;
    logic [CRC_WIDTH-1:0]  w_crc;

    assign w_accept = (r_state == COLLECT) && r_s_ready && s_valid_i;
    assign w_close  = s_last_i || (r_cnt == CNT_W'(BEATS - 1));

    // Bit-serial CRC over the whole payload, padding included, MSB first.
    always_comb begin
        logic w_fb;
        w_crc = '0;
        w_fb  = 1'b0;
        for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
            w_fb  = w_crc[CRC_WIDTH-1] ^ r_data[i];
            w_crc = {w_crc[CRC_WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= COLLECT;
            r_cnt     <= '0;
            r_data    <= '0;
            r_crc     <= '0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    r_s_ready <= 1'b1;
                    if (w_accept) begin
                        for (int k = 0; k < int'(BEATS); k++) begin
                            if (r_cnt == CNT_W'(k))
                                r_data[DATA_WIDTH-1-k*BEAT_WIDTH -: BEAT_WIDTH] <= s_data_i;
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_close) begin
                            r_state   <= CALC;
                            r_s_ready <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    r_crc     <= w_crc;
                    r_state   <= OUTPUT;
                    r_m_valid <= 1'b1;
                end
                OUTPUT: begin
                    // Payload and count are cleared so the next block starts from zero padding.
                    if (m_ready_i) begin
                        r_state   <= COLLECT;
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_cnt     <= '0;
                        r_data    <= '0;
                    end
                end
                default: begin
                    r_state   <= COLLECT;
                    r_s_ready <= 1'b0;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready_o = r_s_ready;
    assign m_valid_o = r_m_valid;
    assign m_data_o  = r_data;
    assign m_crc_o   = r_crc;
    assign m_beats_o = r_cnt;

endmodule
